// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: walks the duty cycle fed to pwm_generator toward a
// requested target in bounded steps. Duty changes are applied only on the
// edge leaving the last phase of a PWM period, so the PWM output never glitches.
// Optional build macro PWM_SEQ_FAULT_EN adds i_fault/i_fault_clear and a
// FAULT state that forces the duty to zero until the fault is cleared.
module pwm_ramp_sequencer #(
  parameter int WIDTH     = 8,
  parameter int RAMP_DIV  = 4,
  parameter int INIT_DUTY = 0
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             i_target_valid,
  input  logic [WIDTH-1:0] i_target_duty,
  input  logic [WIDTH-1:0] i_step,
`ifdef PWM_SEQ_FAULT_EN
  input  logic             i_fault,
  input  logic             i_fault_clear,
`endif
  output logic             o_target_ready,
  output logic [WIDTH-1:0] o_duty_cycle,
  output logic             o_period_start,
  output logic             o_busy,
  output logic             o_done
);

  localparam int               DIV_W      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0] PHASE_LAST = '1;
  localparam logic [WIDTH-1:0] INIT_VAL   = WIDTH'(INIT_DUTY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1
`ifdef PWM_SEQ_FAULT_EN
    ,
    S_FAULT = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;

  logic             boundary;
  logic             going_up;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   step_size;
  logic [WIDTH:0]   duty_stepped;

  assign boundary       = (phase == PHASE_LAST);
  assign o_period_start = (phase == '0);
  assign o_duty_cycle   = duty_q;
  assign o_done         = done_q;

  // Free-running phase counter, reset together with pwm_generator so both stay aligned
  always_ff @(posedge clk_fpga) begin
    if (reset) phase <= '0;
    else       phase <= phase + 1'b1;
  end

  // Next ramp value, clamped so it lands exactly on the target and never wraps
  always_comb begin
    going_up     = (target_q > duty_q);
    diff         = going_up ? ({1'b0, target_q} - {1'b0, duty_q})
                            : ({1'b0, duty_q} - {1'b0, target_q});
    step_size    = ((step_q == '0) || ({1'b0, step_q} >= diff)) ? diff : {1'b0, step_q};
    duty_stepped = going_up ? ({1'b0, duty_q} + step_size)
                            : ({1'b0, duty_q} - step_size);
  end

  // Sequencer state register
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q  <= S_IDLE;
      duty_q   <= INIT_VAL;
      target_q <= INIT_VAL;
      step_q   <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      div_q    <= div_d;
      done_q   <= done_d;
    end
  end

  // Next-state, handshake and status logic
  always_comb begin
    state_d        = state_q;
    duty_d         = duty_q;
    target_d       = target_q;
    step_d         = step_q;
    div_d          = div_q;
    done_d         = 1'b0;
    o_target_ready = 1'b0;
    o_busy         = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_target_ready = 1'b1;
        if (i_target_valid) begin
          target_d = i_target_duty;
          step_d   = i_step;
          if (i_target_duty == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RAMP;
            div_d   = '0;
          end
        end
      end
      S_RAMP: begin
        o_busy = 1'b1;
        if (boundary) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            duty_d = duty_stepped[WIDTH-1:0];
            if (duty_stepped == {1'b0, target_q}) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
`ifdef PWM_SEQ_FAULT_EN
      S_FAULT: begin
        duty_d = '0;
        if (i_fault_clear) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef PWM_SEQ_FAULT_EN
    if (i_fault) begin
      state_d        = S_FAULT;
      duty_d         = '0;
      done_d         = 1'b0;
      o_target_ready = 1'b0;
    end
`endif
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Controller that sequences the duty-cycle input of pwm_generator. Accepts target-duty requests over a valid/ready handshake and ramps the applied duty toward the target in bounded steps. Updates take effect only at PWM period boundaries, so the PWM output never glitches. Sits between the control/register logic and pwm_generator, with o_duty_cycle wired directly to i_duty_cycle.

Parameters:
WIDTH, 8, duty/period counter width; PWM period = 2^WIDTH cycles (must match pwm_generator WIDTH)
RAMP_DIV, 4, number of PWM periods between ramp steps (>=1)
INIT_DUTY, 0, duty applied out of reset (WIDTH bits)

Ports:
clk_fpga  in  1  system clock (same clock as pwm_generator)
reset  in  1  synchronous, active-high reset
i_target_valid  in  1  new target request valid
i_target_duty  in  WIDTH  requested duty
i_step  in  WIDTH  max duty change per ramp step; 0 = jump directly to target
o_target_ready  out  1  request accepted when valid&&ready
o_duty_cycle  out  WIDTH  registered duty to pwm_generator
o_period_start  out  1  high while phase counter == 0
o_busy  out  1  ramp in progress
o_done  out  1  one-cycle pulse when duty reaches target

Behaviour:
- Single clock, synchronous active-high reset; all state updates on posedge clk_fpga.
- Reset values: phase counter 0, o_duty_cycle=INIT_DUTY, state IDLE, period-divider 0, o_target_ready=1, o_busy=0, o_done=0, o_period_start=1.
- Phase counter: free-running WIDTH-bit counter; +1 every cycle, wraps 2^WIDTH-1 -> 0. It is released from the same reset as pwm_generator, so it stays aligned with the generator's counter.
- Boundary: cycle where phase == 2^WIDTH-1. o_duty_cycle changes only on the edge leaving a boundary cycle, so the new duty is valid from phase 0.
- States:
  - IDLE: o_target_ready=1.
    - On accept, latch target and step.
    - target == current duty: stay IDLE and pulse o_done next cycle.
    - Otherwise go to RAMP and clear the period-divider.
  - RAMP: o_target_ready=0, o_busy=1.
    - Period-divider increments at each boundary.
    - When the divider reaches RAMP_DIV-1 at a boundary: apply a step and reset the divider.
    - Step size = min(step, |target-duty|); step 0 means the full difference.
    - Compute in WIDTH+1 bits. The result never overshoots the target and never wraps past 0 or 2^WIDTH-1.
    - When the applied duty equals the target: go to IDLE and pulse o_done on the same edge the final duty is applied.
- Requests arriving during RAMP are not accepted; valid must be held (standard valid/ready).
- First step latency: the first boundary at which the divider reaches RAMP_DIV-1. With RAMP_DIV=1, that is the next boundary after acceptance.
- Accept on a boundary cycle: the accept cycle's boundary does not count toward the divider.
- Reset mid-ramp: next cycle returns to reset values, target discarded, o_duty_cycle=INIT_DUTY immediately (the generator sees the new duty together with its own counter reset).
- Target 0 and target 2^WIDTH-1 are both legal endpoints.

Optional Feature:
PWM_SEQ_FAULT_EN
- Defined: adds inputs i_fault (1) and i_fault_clear (1) and state FAULT.
  - i_fault high in any state: o_duty_cycle=0 on the next edge, regardless of boundary.
  - Enter FAULT: o_target_ready=0, o_busy=0, any ramp aborted, no o_done.
  - FAULT holds until i_fault_clear=1 with i_fault=0, then go to IDLE with duty 0.
  - i_fault has priority over i_fault_clear and over requests.
- Undefined: ports absent, FAULT state absent, behaviour as above.

Test Plan:
1. WIDTH=4, RAMP_DIV=1, INIT_DUTY=0, then reset release -> o_duty_cycle=0, o_target_ready=1, o_period_start high every 16th cycle starting at the first cycle.
2. Request target=10, step=3 -> duty sequence 3,6,9,10 applied at four consecutive phase-0 cycles; o_done pulses with 10; o_busy low afterward.
3. RAMP_DIV=2, from duty 10 request target=2, step=4 -> duty 6 then 2, each 32 cycles apart; no underflow; ready low throughout the ramp.
4. Request target = current duty -> stay IDLE, o_done pulse next cycle, duty unchanged; request with step=0, target=15 -> jumps to 15 at the next boundary.
5. Assert reset mid-ramp (duty 6 heading to 12) -> next cycle duty=INIT_DUTY, phase=0, o_busy=0; a held valid is not accepted while reset is high.
6. PWM_SEQ_FAULT_EN defined: i_fault at phase 5 during a ramp -> duty 0 next cycle, ready 0; i_fault_clear with fault low -> IDLE, duty 0, ready 1.
